// File: rtl/iterate_sweep.sv
// iterate_sweep: coordinate-descent sweep engine for an L1-regularised
// least-squares problem in fixed point (N-bit two's complement, Q fractional
// bits). Each sweep walks the J columns of A: DOT forms A_j.r over I cycles,
// UPD applies the soft-threshold coefficient update, RES folds the change
// back into the residual over I cycles (skipped when the coefficient did
// not move). CHK counts sweeps and decides whether to stop.
//
// Build option: define ITERATE_SWEEP_EARLY_STOP_EN to let CHK also stop as
// soon as the largest coefficient change of a sweep is <= tol. Without it,
// tol is ignored and exactly num_sweeps sweeps (0 treated as 1) always run.
module iterate_sweep #(
    parameter int I    = 10,
    parameter int J    = 2,
    parameter int N    = 8,
    parameter int Q    = 3,
    parameter int SW_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [J-1:0][N-1:0]          xhat_in,
    input  logic [I-1:0][J-1:0][N-1:0]   A,
    input  logic [J-1:0][N-1:0]          A_inv2_in,
    input  logic [N-1:0]                 max_xj_in,
    input  logic [I-1:0][N-1:0]          r_in,
    input  logic [N-1:0]                 lambda,
    input  logic [SW_W-1:0]              num_sweeps,
    input  logic [N-1:0]                 tol,
    output logic [I-1:0][N-1:0]          r_out,
    output logic [J-1:0][N-1:0]          xhat_out,
    output logic [N-1:0]                 max_xj_out,
    output logic [N-1:0]                 max_dxj_out,
    output logic [SW_W-1:0]              sweeps_done,
    output logic                         busy,
    output logic                         done
);

    localparam int ACC_W = 2 * N + $clog2(I);
    localparam int WIDE  = ACC_W + 2;
    localparam int I_W   = (I > 1) ? $clog2(I) : 1;
    localparam int J_W   = (J > 1) ? $clog2(J) : 1;

    localparam logic [I_W-1:0]  I_LAST = I_W'(I - 1);
    localparam logic [I_W-1:0]  I_ONE  = I_W'(1);
    localparam logic [J_W-1:0]  J_LAST = J_W'(J - 1);
    localparam logic [J_W-1:0]  J_ONE  = J_W'(1);
    localparam logic [SW_W-1:0] SW_ONE = SW_W'(1);

    localparam logic signed [N-1:0]    N_MAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]    N_MIN   = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DOT  = 3'd2,
        ST_UPD  = 3'd3,
        ST_RES  = 3'd4,
        ST_CHK  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Clamp a wide signed intermediate into the N-bit signed range.
    function automatic logic signed [N-1:0] sat_n(input logic signed [WIDE-1:0] v);
        logic signed [N-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[N-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[N-1:0];
        end else begin
            res = v[N-1:0];
        end
        return res;
    endfunction

    // Sign-extend an N-bit value to the working width.
    function automatic logic signed [WIDE-1:0] sx(input logic signed [N-1:0] v);
        return {{(WIDE-N){v[N-1]}}, v};
    endfunction

    // Magnitude with the most-negative value pinned to the largest positive.
    function automatic logic [N-1:0] abs_sat(input logic signed [N-1:0] v);
        logic [N-1:0] res;
        if (v == N_MIN) begin
            res = N_MAX;
        end else if (v[N-1]) begin
            res = -v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t                       state_r;
    logic [I_W-1:0]               i_r;
    logic [J_W-1:0]               j_r;
    logic signed [ACC_W-1:0]      acc_r;
    logic signed [N-1:0]          dx_r;
    logic [J-1:0][N-1:0]          xhat_r;
    logic [I-1:0][N-1:0]          r_r;
    logic [J-1:0][N-1:0]          ainv2_r;
    logic [N-1:0]                 lambda_r;
    logic [SW_W-1:0]              nsw_r;
    logic [N-1:0]                 max_xj_r;
    logic [N-1:0]                 max_dxj_r;
    logic [SW_W-1:0]              sweeps_r;
    logic                         busy_r;
    logic                         done_r;
`ifdef ITERATE_SWEEP_EARLY_STOP_EN
    logic [N-1:0]                 tol_r;
`else
    logic                         unused_tol_s;
`endif

    logic signed [N-1:0]          a_ij_s;
    logic signed [N-1:0]          r_i_s;
    logic signed [N-1:0]          xhat_j_s;
    logic signed [N-1:0]          ainv_j_s;
    logic signed [N-1:0]          lambda_s;
    logic signed [WIDE-1:0]       dot_prod_s;
    logic signed [ACC_W-1:0]      acc_next_s;
    logic signed [WIDE-1:0]       acc_w_s;
    logic signed [N-1:0]          rho_s;
    logic signed [WIDE-1:0]       rho_prod_s;
    logic signed [N-1:0]          step_s;
    logic signed [N-1:0]          z_s;
    logic signed [WIDE-1:0]       thr_prod_s;
    logic signed [N-1:0]          thr_s;
    logic signed [WIDE-1:0]       xn_w_s;
    logic signed [N-1:0]          xnew_s;
    logic signed [N-1:0]          dx_s;
    logic [N-1:0]                 dx_abs_s;
    logic [N-1:0]                 xnew_abs_s;
    logic signed [WIDE-1:0]       res_prod_s;
    logic signed [N-1:0]          res_sub_s;
    logic signed [N-1:0]          r_new_s;
    logic [SW_W-1:0]              sweeps_next_s;
    logic [SW_W-1:0]              limit_s;
    logic                         stop_s;

    // Arithmetic for the current (i, j): DOT accumulate, UPD soft threshold, RES residual update.
    always_comb begin
        a_ij_s     = $signed(A[i_r][j_r]);
        r_i_s      = $signed(r_r[i_r]);
        xhat_j_s   = $signed(xhat_r[j_r]);
        ainv_j_s   = $signed(ainv2_r[j_r]);
        lambda_s   = $signed(lambda_r);

        dot_prod_s = sx(a_ij_s) * sx(r_i_s);
        acc_next_s = acc_r + $signed(dot_prod_s[ACC_W-1:0]);

        acc_w_s    = {{(WIDE-ACC_W){acc_r[ACC_W-1]}}, acc_r};
        rho_s      = sat_n(acc_w_s >>> Q);
        rho_prod_s = sx(rho_s) * sx(ainv_j_s);
        step_s     = sat_n(rho_prod_s >>> Q);
        z_s        = sat_n(sx(xhat_j_s) + sx(step_s));
        thr_prod_s = sx(lambda_s) * sx(ainv_j_s);
        thr_s      = sat_n(thr_prod_s >>> Q);

        if (sx(z_s) > sx(thr_s)) begin
            xn_w_s = sx(z_s) - sx(thr_s);
        end else if (sx(z_s) < -sx(thr_s)) begin
            xn_w_s = sx(z_s) + sx(thr_s);
        end else begin
            xn_w_s = '0;
        end
        xnew_s     = sat_n(xn_w_s);
        dx_s       = sat_n(sx(xnew_s) - sx(xhat_j_s));
        dx_abs_s   = abs_sat(dx_s);
        xnew_abs_s = abs_sat(xnew_s);

        res_prod_s = sx(a_ij_s) * sx(dx_r);
        res_sub_s  = sat_n(res_prod_s >>> Q);
        r_new_s    = sat_n(sx(r_i_s) - sx(res_sub_s));
    end

    // Sweep bookkeeping for CHK: next count, effective limit, stop decision.
    always_comb begin
        sweeps_next_s = sweeps_r + SW_ONE;
        if (nsw_r == '0) begin
            limit_s = SW_ONE;
        end else begin
            limit_s = nsw_r;
        end
`ifdef ITERATE_SWEEP_EARLY_STOP_EN
        stop_s = (sweeps_next_s >= limit_s) || (max_dxj_r <= tol_r);
`else
        stop_s = (sweeps_next_s >= limit_s);
`endif
    end

`ifndef ITERATE_SWEEP_EARLY_STOP_EN
    assign unused_tol_s = ^tol;
`endif

    // Main sequencer: owns every register, including the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            i_r       <= '0;
            j_r       <= '0;
            acc_r     <= '0;
            dx_r      <= '0;
            xhat_r    <= '0;
            r_r       <= '0;
            ainv2_r   <= '0;
            lambda_r  <= '0;
            nsw_r     <= '0;
            max_xj_r  <= '0;
            max_dxj_r <= '0;
            sweeps_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef ITERATE_SWEEP_EARLY_STOP_EN
            tol_r     <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        xhat_r    <= xhat_in;
                        ainv2_r   <= A_inv2_in;
                        max_xj_r  <= max_xj_in;
                        r_r       <= r_in;
                        lambda_r  <= lambda;
                        nsw_r     <= num_sweeps;
`ifdef ITERATE_SWEEP_EARLY_STOP_EN
                        tol_r     <= tol;
`endif
                        j_r       <= '0;
                        sweeps_r  <= '0;
                        max_dxj_r <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    i_r     <= '0;
                    j_r     <= '0;
                    acc_r   <= '0;
                    state_r <= ST_DOT;
                end
                ST_DOT: begin
                    acc_r <= acc_next_s;
                    if (i_r == I_LAST) begin
                        i_r     <= '0;
                        state_r <= ST_UPD;
                    end else begin
                        i_r <= i_r + I_ONE;
                    end
                end
                ST_UPD: begin
                    xhat_r[j_r] <= xnew_s;
                    dx_r        <= dx_s;
                    i_r         <= '0;
                    if (dx_abs_s > max_dxj_r) begin
                        max_dxj_r <= dx_abs_s;
                    end
                    if (xnew_abs_s > max_xj_r) begin
                        max_xj_r <= xnew_abs_s;
                    end
                    if (dx_s != '0) begin
                        state_r <= ST_RES;
                    end else if (j_r == J_LAST) begin
                        state_r <= ST_CHK;
                    end else begin
                        j_r     <= j_r + J_ONE;
                        acc_r   <= '0;
                        state_r <= ST_DOT;
                    end
                end
                ST_RES: begin
                    r_r[i_r] <= r_new_s;
                    if (i_r != I_LAST) begin
                        i_r <= i_r + I_ONE;
                    end else if (j_r == J_LAST) begin
                        i_r     <= '0;
                        state_r <= ST_CHK;
                    end else begin
                        i_r     <= '0;
                        j_r     <= j_r + J_ONE;
                        acc_r   <= '0;
                        state_r <= ST_DOT;
                    end
                end
                ST_CHK: begin
                    sweeps_r <= sweeps_next_s;
                    if (stop_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        j_r       <= '0;
                        i_r       <= '0;
                        acc_r     <= '0;
                        max_dxj_r <= '0;
                        state_r   <= ST_DOT;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign r_out       = r_r;
    assign xhat_out    = xhat_r;
    assign max_xj_out  = max_xj_r;
    assign max_dxj_out = max_dxj_r;
    assign sweeps_done = sweeps_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_iterate_sweep.sv
// Bench for iterate_sweep: directed cases plus randomized runs, each compared
// against a loop-level arithmetic model of the sweep algorithm.
module tb_iterate_sweep;

    localparam int I    = 10;
    localparam int J    = 2;
    localparam int N    = 8;
    localparam int Q    = 3;
    localparam int SW_W = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start;
    logic [J-1:0][N-1:0]         xhat_in;
    logic [I-1:0][J-1:0][N-1:0]  a;
    logic [J-1:0][N-1:0]         ainv;
    logic [N-1:0]                max_xj_in;
    logic [I-1:0][N-1:0]         r_in;
    logic [N-1:0]                lambda;
    logic [SW_W-1:0]             num_sweeps;
    logic [N-1:0]                tol;
    logic [I-1:0][N-1:0]         r_out;
    logic [J-1:0][N-1:0]         xhat_out;
    logic [N-1:0]                max_xj_out;
    logic [N-1:0]                max_dxj_out;
    logic [SW_W-1:0]             sweeps_done;
    logic                        busy;
    logic                        done;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    iterate_sweep #(.I(I), .J(J), .N(N), .Q(Q), .SW_W(SW_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .xhat_in(xhat_in), .A(a),
        .A_inv2_in(ainv), .max_xj_in(max_xj_in), .r_in(r_in), .lambda(lambda),
        .num_sweeps(num_sweeps), .tol(tol), .r_out(r_out), .xhat_out(xhat_out),
        .max_xj_out(max_xj_out), .max_dxj_out(max_dxj_out),
        .sweeps_done(sweeps_done), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [I-1:0][N-1:0] exp_r;
    logic [J-1:0][N-1:0] exp_x;
    logic [N-1:0]        exp_mx;
    logic [N-1:0]        exp_mdx;
    int                  exp_sw;
    int                  exp_cyc;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input longint v);
        longint hi = (64'sd1 <<< (N-1)) - 64'sd1;
        longint lo = -(64'sd1 <<< (N-1));
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    function automatic int asr(input longint v);
        return int'(v >>> Q);
    endfunction

    function automatic int s8(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int mag(input int v);
        int m = (v < 0) ? -v : v;
        return (m > (1 << (N-1)) - 1) ? (1 << (N-1)) - 1 : m;
    endfunction

    // Reference: the sweep algorithm written as plain loops over the current inputs.
    task automatic model_run();
        int x[J];
        int r[I];
        int mx, mdx, sw, cyc, lim, acc, rho, z, thr, xn, dx;
        bit stop;
        for (int j = 0; j < J; j++) x[j] = s8(xhat_in[j]);
        for (int i = 0; i < I; i++) r[i] = s8(r_in[i]);
        mx   = int'(max_xj_in);
        mdx  = 0;
        sw   = 0;
        cyc  = 1;
        lim  = (num_sweeps == 0) ? 1 : int'(num_sweeps);
        stop = 1'b0;
        while (!stop) begin
            mdx = 0;
            for (int j = 0; j < J; j++) begin
                acc = 0;
                for (int i = 0; i < I; i++) acc += s8(a[i][j]) * r[i];
                cyc += I + 1;
                rho = sat(asr(acc));
                z   = sat(x[j] + sat(asr(rho * s8(ainv[j]))));
                thr = sat(asr(s8(lambda) * s8(ainv[j])));
                if (z > thr)       xn = z - thr;
                else if (z < -thr) xn = z + thr;
                else               xn = 0;
                xn  = sat(xn);
                dx  = sat(xn - x[j]);
                x[j] = xn;
                if (mag(dx) > mdx) mdx = mag(dx);
                if (mag(xn) > mx)  mx  = mag(xn);
                if (dx != 0) begin
                    for (int i = 0; i < I; i++) r[i] = sat(r[i] - sat(asr(s8(a[i][j]) * dx)));
                    cyc += I;
                end
            end
            cyc += 1;
            sw++;
            stop = (sw >= lim);
`ifdef ITERATE_SWEEP_EARLY_STOP_EN
            if (mdx <= int'(tol)) stop = 1'b1;
`endif
        end
        cyc += 1;
        for (int i = 0; i < I; i++) exp_r[i] = N'(r[i]);
        for (int j = 0; j < J; j++) exp_x[j] = N'(x[j]);
        exp_mx  = N'(mx);
        exp_mdx = N'(mdx);
        exp_sw  = sw;
        exp_cyc = cyc;
    endtask

    task automatic clear_inputs();
        start = 1'b0; xhat_in = '0; a = '0; ainv = '0; max_xj_in = '0;
        r_in = '0; lambda = '0; num_sweeps = '0; tol = '0;
    endtask

    // Launch one operation, wait (bounded) for done, compare against the model.
    task automatic run_case(input string name, input bit poke, output int lat);
        int  cnt;
        bit  got;
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({name, "/busy"}, 128'(busy), 128'(1));
        cnt = 0;
        got = 1'b0;
        while (cnt < 3000 && !got) begin
            start = (poke && cnt == 3) ? 1'b1 : 1'b0;
            tick();
            cnt++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        lat = cnt;
        check_eq({name, "/latency"}, 128'(cnt), 128'(exp_cyc - 1));
        check_eq({name, "/r_out"}, 128'(r_out), 128'(exp_r));
        check_eq({name, "/xhat_out"}, 128'(xhat_out), 128'(exp_x));
        check_eq({name, "/max_xj"}, 128'(max_xj_out), 128'(exp_mx));
        check_eq({name, "/max_dxj"}, 128'(max_dxj_out), 128'(exp_mdx));
        check_eq({name, "/sweeps"}, 128'(sweeps_done), 128'(exp_sw));
        tick();
        check_eq({name, "/done_pulse"}, 128'({busy, done}), 128'(0));
    endtask

    initial begin
        int lat;
        int seen;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst/r_out", 128'(r_out), 128'(0));
        check_eq("rst/xhat_out", 128'(xhat_out), 128'(0));
        check_eq("rst/max", 128'({max_xj_out, max_dxj_out, sweeps_done}), 128'(0));
        check_eq("rst/busy_done", 128'({busy, done}), 128'(0));
        rst_n = 1'b1;
        tick();

        // Zero matrix: both residual updates skipped.
        for (int i = 0; i < I; i++) r_in[i] = N'(i * 7 + 1);
        num_sweeps = 4'd1;
        run_case("zeroA", 1'b0, lat);
        check_eq("zeroA/lat24", 128'(lat), 128'(24));
        check_eq("zeroA/r_eq_in", 128'(r_out), 128'(r_in));

        // Single nonzero entry, one sweep, with start poked while busy.
        clear_inputs();
        a[0][0] = 8'h08; r_in[0] = 8'h10; ainv = {8'h08, 8'h08};
        lambda = 8'h02; num_sweeps = 4'd1;
        run_case("single", 1'b1, lat);
        check_eq("single/x0", 128'(xhat_out[0]), 128'(8'h0E));
        check_eq("single/r0", 128'(r_out[0]), 128'(8'h02));
        check_eq("single/mdx", 128'(max_dxj_out), 128'(8'h0E));
        check_eq("single/mx", 128'(max_xj_out), 128'(8'h0E));

        // Same problem, eight sweeps, tol 1.
        num_sweeps = 4'd8; tol = 8'h01;
        run_case("multi", 1'b0, lat);
        check_eq("multi/x0", 128'(xhat_out[0]), 128'(8'h0E));
        check_eq("multi/mdx", 128'(max_dxj_out), 128'(8'h00));
`ifdef ITERATE_SWEEP_EARLY_STOP_EN
        check_eq("multi/sw", 128'(sweeps_done), 128'(2));
`else
        check_eq("multi/sw", 128'(sweeps_done), 128'(8));
`endif

        // Saturating case: everything at full positive scale.
        clear_inputs();
        a = '1; for (int i = 0; i < I; i++) for (int j = 0; j < J; j++) a[i][j] = 8'h7F;
        for (int i = 0; i < I; i++) r_in[i] = 8'h7F;
        ainv = {8'h08, 8'h08}; num_sweeps = 4'd1;
        run_case("satur", 1'b0, lat);
        check_eq("satur/x0", 128'(xhat_out[0]), 128'(8'h7F));

        // num_sweeps 0 behaves as one sweep.
        num_sweeps = 4'd0;
        run_case("zero_sw", 1'b0, lat);

        // Reset mid-DOT with start held: abort, no done, stays idle.
        num_sweeps = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0;
        check_eq("abort/busy_done", 128'({busy, done}), 128'(0));
        check_eq("abort/r_out", 128'(r_out), 128'(0));
        check_eq("abort/regs", 128'({xhat_out, max_xj_out, max_dxj_out, sweeps_done}), 128'(0));
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done || busy) seen++;
        end
        check_eq("abort/quiet", 128'(seen), 128'(0));

        // Randomized problems.
        for (int t = 0; t < 25; t++) begin
            clear_inputs();
            for (int i = 0; i < I; i++) begin
                r_in[i] = N'($urandom_range(0, 255));
                for (int j = 0; j < J; j++) a[i][j] = N'($urandom_range(0, 255));
            end
            for (int j = 0; j < J; j++) begin
                xhat_in[j] = N'($urandom_range(0, 255));
                ainv[j]    = N'($urandom_range(0, 16));
            end
            max_xj_in  = N'($urandom_range(0, 255));
            lambda     = N'($urandom_range(0, 15));
            num_sweeps = SW_W'($urandom_range(0, 4));
            tol        = N'($urandom_range(0, 7));
            run_case($sformatf("rand%0d", t), t[0], lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iterate_sweep.md
ITERATE_SWEEP -- requirements
Module: iterate_sweep

Interface
REQ-001 Parameter I, default 10: residual length (rows of A), >=2.
REQ-002 Parameter J, default 2: coefficient count (columns of A), >=1.
REQ-003 Parameter N, default 8: two's-complement data width.
REQ-004 Parameter Q, default 3: fractional bits, Q<N.
REQ-005 Parameter SW_W, default 4: sweep-count width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 start  in  1  launch request, sampled only in IDLE.
REQ-009 xhat_in  in  [J]xN  initial coefficients.
REQ-010 A  in  [I][J]xN  matrix; SHALL be held stable start..done.
REQ-011 A_inv2_in  in  [J]xN  1/||A_j||^2 per column.
REQ-012 max_xj_in  in  N  initial running max |x|.
REQ-013 r_in  in  [I]xN  initial residual.
REQ-014 lambda  in  N  L1 weight.
REQ-015 num_sweeps  in  SW_W  sweep limit; 0 treated as 1.
REQ-016 tol  in  N  early-stop tolerance (unsigned magnitude).
REQ-017 r_out, xhat_out  out  [I]xN, [J]xN  working registers.
REQ-018 max_xj_out, max_dxj_out  out  N  running max |x|; max |dx| of last sweep.
REQ-019 sweeps_done  out  SW_W  completed sweeps.
REQ-020 busy  out  1  high from the cycle after accepted start until done; done  out  1  one-cycle pulse on completion.

Function
REQ-021 States: IDLE, LOAD, DOT, UPD, RES, CHK, DONE; DONE lasts one cycle then IDLE.
REQ-022 IDLE+start -> LOAD: capture xhat_in, A_inv2_in, max_xj_in, r_in, lambda, num_sweeps, tol; j=0, sweeps_done=0, max_dxj=0.
REQ-023 DOT: I cycles, acc += A[i][j]*r[i], acc width 2N+clog2(I).
REQ-024 UPD (1 cycle): rho=sat_N(acc>>>Q); z=sat_N(xhat[j]+sat_N((rho*A_inv2[j])>>>Q)); thr=sat_N((lambda*A_inv2[j])>>>Q).
REQ-025 Soft threshold: xnew = z-thr if z>thr; z+thr if z<-thr; else 0; dx=sat_N(xnew-xhat[j]); xhat[j]<=xnew.
REQ-026 UPD updates max_dxj=max(max_dxj,|dx|), max_xj=max(max_xj,|xnew|); |most-negative| saturates to 2^(N-1)-1.
REQ-027 RES: I cycles, r[i] <= sat_N(r[i] - sat_N((A[i][j]*dx)>>>Q)); skipped entirely when dx==0.
REQ-028 After RES/skip: j<J-1 -> j+1, DOT; else CHK.
REQ-029 CHK (1 cycle): sweeps_done+1; stop -> DONE if count reaches limit (or early-stop REQ-036); else j=0, max_dxj=0, DOT.
REQ-030 Latency start->done, no skips: 1 + S*(J*(2I+1)+1) + 1 cycles; each skipped RES removes I cycles.
REQ-031 >>> is arithmetic shift (floor); sat_N clamps to [-2^(N-1), 2^(N-1)-1].
REQ-032 start while busy is ignored; outputs hold final values in IDLE until next accepted start.

Reset
REQ-033 rst_n low at a clock edge: state IDLE; all outputs, working registers, counters 0; busy=done=0.
REQ-034 Reset mid-operation aborts immediately, no done pulse; start in the same cycle as rst_n low is ignored.

Configuration
REQ-035 Macro ITERATE_SWEEP_EARLY_STOP_EN selects early termination.
REQ-036 Defined: CHK also stops when max_dxj<=tol. Undefined: tol ignored, exactly num_sweeps sweeps always run.

Verification (I=10, J=2, N=8, Q=3)
REQ-037 Reset: rst_n=0 two cycles -> all outputs 0, busy=0, done=0.
REQ-038 A all 0, xhat_in 0, num_sweeps=1 -> done 24 cycles after accepted start, r_out==r_in, xhat_out 0, max_dxj_out 0.
REQ-039 A[0][0]=8'h08 else 0, r_in[0]=8'h10 else 0, A_inv2=8'h08, lambda=8'h02, num_sweeps=1 -> xhat_out[0]=8'h0E, r_out[0]=8'h02, max_dxj_out=8'h0E, max_xj_out=8'h0E.
REQ-040 As REQ-039, num_sweeps=8, tol=8'h01 -> with macro sweeps_done=2, max_dxj_out=0; without macro sweeps_done=8, values unchanged after sweep 2.
REQ-041 A all 8'h7F, r_in all 8'h7F, A_inv2 8'h08, lambda 0 -> rho saturates 8'h7F, no wrap in any r_out.
REQ-042 start pulsed while busy -> no restart; rst_n low mid-DOT -> IDLE, no done pulse.
